// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone arbiter family: arbitration
// mode encodings, arbiter FSM states and an elaboration-time ceil(log2).
package wb_arb_pkg;

   typedef enum logic {
      ARB_PRIORITY,
      ARB_ROUND_ROBIN
   } arb_type_t;

   typedef enum logic {
      LSB_HIGH,
      LSB_LOW
   } lsb_prio_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_t;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/wb_arb_grant.sv
// Registered one-hot grant engine (fixed priority or round robin).
// Loads a new grant only when arb_en is high; an empty request vector loads 0.
module wb_arb_grant
   import wb_arb_pkg::*;
#(
   parameter int    PORTS        = 4,
   parameter string ARB_TYPE     = "ROUND_ROBIN",
   parameter string LSB_PRIORITY = "HIGH",
   localparam int   IDX_W        = clog2(PORTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] request,
   input  logic             arb_en,
   output logic [PORTS-1:0] grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] rr_ptr
);

   localparam arb_type_t ARB_MODE = (ARB_TYPE == "PRIORITY") ? ARB_PRIORITY : ARB_ROUND_ROBIN;
   localparam lsb_prio_t LSB_MODE = (LSB_PRIORITY == "LOW") ? LSB_LOW : LSB_HIGH;
   localparam logic [IDX_W-1:0] TOP_IDX = (LSB_MODE == LSB_HIGH) ? '0 : IDX_W'(PORTS - 1);

   logic [PORTS-1:0] winner;
   logic [IDX_W-1:0] winner_idx;
   logic [IDX_W-1:0] next_ptr;
   logic             found;

   // rr_ptr holds the index the next search starts from, not the last winner
   always_comb begin
      int start;
      int idx;
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      start      = (ARB_MODE == ARB_ROUND_ROBIN) ? int'(rr_ptr) : int'(TOP_IDX);
      for (int i = 0; i < PORTS; i++) begin
         if (LSB_MODE == LSB_HIGH) begin
            idx = start + i;
            if (idx >= PORTS) idx = idx - PORTS;
         end else begin
            idx = start - i;
            if (idx < 0) idx = idx + PORTS;
         end
         if (!found && request[idx]) begin
            winner[idx] = 1'b1;
            winner_idx  = IDX_W'(idx);
            found       = 1'b1;
         end
      end
   end

   always_comb begin
      if (LSB_MODE == LSB_HIGH)
         next_ptr = (int'(winner_idx) == PORTS - 1) ? '0 : winner_idx + IDX_W'(1);
      else
         next_ptr = (winner_idx == '0) ? IDX_W'(PORTS - 1) : winner_idx - IDX_W'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant  <= '0;
         rr_ptr <= TOP_IDX;
      end else if (arb_en) begin
         grant <= winner;
         if (found) rr_ptr <= next_ptr;
      end
   end

   assign grant_valid = |grant;

endmodule

// File: rtl/wb_arbiter_n.sv
// N-port Wishbone classic arbiter/mux with a per-transfer watchdog that
// aborts a hung slave access with an error to the granted master.
module wb_arbiter_n
   import wb_arb_pkg::*;
#(
   parameter int    PORTS        = 4,
   parameter int    DATA_WIDTH   = 32,
   parameter int    ADDR_WIDTH   = 32,
   parameter int    SELECT_WIDTH = DATA_WIDTH / 8,
   parameter string ARB_TYPE     = "ROUND_ROBIN",
   parameter string LSB_PRIORITY = "HIGH",
   parameter int    TIMEOUT      = 256
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [PORTS*ADDR_WIDTH-1:0]    wbm_adr_i,
   input  logic [PORTS*DATA_WIDTH-1:0]    wbm_dat_i,
   output logic [PORTS*DATA_WIDTH-1:0]    wbm_dat_o,
   input  logic [PORTS-1:0]               wbm_we_i,
   input  logic [PORTS*SELECT_WIDTH-1:0]  wbm_sel_i,
   input  logic [PORTS-1:0]               wbm_stb_i,
   input  logic [PORTS-1:0]               wbm_cyc_i,
   output logic [PORTS-1:0]               wbm_ack_o,
   output logic [PORTS-1:0]               wbm_err_o,
   output logic [PORTS-1:0]               wbm_rty_o,
   output logic [ADDR_WIDTH-1:0]          wbs_adr_o,
   output logic [DATA_WIDTH-1:0]          wbs_dat_o,
   output logic                           wbs_we_o,
   output logic [SELECT_WIDTH-1:0]        wbs_sel_o,
   output logic                           wbs_stb_o,
   output logic                           wbs_cyc_o,
   input  logic [DATA_WIDTH-1:0]          wbs_dat_i,
   input  logic                           wbs_ack_i,
   input  logic                           wbs_err_i,
   input  logic                           wbs_rty_i,
   output logic [PORTS-1:0]               grant_o,
   output logic                           timeout_o
);

   localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_t             state;
   arb_state_t             state_next;
   logic [PORTS-1:0]       grant;
   logic                   grant_valid;
   logic [clog2(PORTS)-1:0] rr_ptr_unused;
   logic                   arb_en;
   logic                   any_req;
   logic                   granted_cyc;
   logic                   granted_stb;
   logic                   terminated;
   logic                   wd_fire;
   logic [CNT_W-1:0]       wd_cnt;

   wb_arb_grant #(
      .PORTS        (PORTS),
      .ARB_TYPE     (ARB_TYPE),
      .LSB_PRIORITY (LSB_PRIORITY)
   ) u_grant (
      .clk         (clk),
      .rst         (rst),
      .request     (wbm_cyc_i),
      .arb_en      (arb_en),
      .grant       (grant),
      .grant_valid (grant_valid),
      .rr_ptr      (rr_ptr_unused)
   );

   assign any_req     = |wbm_cyc_i;
   assign granted_cyc = |(grant & wbm_cyc_i);
   assign granted_stb = |(grant & wbm_stb_i);
   assign terminated  = wbs_ack_i | wbs_err_i | wbs_rty_i;
   // A termination in the limit cycle suppresses the abort
   assign wd_fire     = (TIMEOUT > 0) && (state == ST_GRANT) && granted_stb &&
                        !terminated && (wd_cnt == WD_LIMIT);

   always_ff @(posedge clk) begin
      if (rst || !wbs_stb_o || terminated)
         wd_cnt <= '0;
      else if (wd_cnt != '1)
         wd_cnt <= wd_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:
            if (any_req) state_next = ST_GRANT;
         ST_GRANT:
            if (wd_fire)           state_next = ST_ABORT;
            else if (!granted_cyc) state_next = any_req ? ST_GRANT : ST_IDLE;
         ST_ABORT:
            if (granted_cyc) state_next = ST_GRANT;
            else             state_next = any_req ? ST_GRANT : ST_IDLE;
         default:
            state_next = ST_IDLE;
      endcase
   end

   // After an abort the same master keeps the bus if it still holds cyc
   always_comb begin
      arb_en    = 1'b0;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      timeout_o = 1'b0;
      case (state)
         ST_IDLE: arb_en = 1'b1;
         ST_GRANT: begin
            arb_en    = !wd_fire && !granted_cyc;
            wbs_cyc_o = grant_valid;
            wbs_stb_o = granted_stb;
            wbm_ack_o = grant & {PORTS{wbs_ack_i}};
            wbm_err_o = grant & {PORTS{wbs_err_i}};
            wbm_rty_o = grant & {PORTS{wbs_rty_i}};
         end
         ST_ABORT: begin
            arb_en    = !granted_cyc;
            wbm_err_o = grant;
            timeout_o = 1'b1;
         end
         default: arb_en = 1'b0;
      endcase
   end

   // One-hot grant lets the mux be a plain AND-OR tree
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_we_o  = 1'b0;
      wbs_sel_o = '0;
      for (int k = 0; k < PORTS; k++) begin
         wbs_adr_o = wbs_adr_o | ({ADDR_WIDTH{grant[k]}} & wbm_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
         wbs_dat_o = wbs_dat_o | ({DATA_WIDTH{grant[k]}} & wbm_dat_i[k*DATA_WIDTH +: DATA_WIDTH]);
         wbs_sel_o = wbs_sel_o | ({SELECT_WIDTH{grant[k]}} & wbm_sel_i[k*SELECT_WIDTH +: SELECT_WIDTH]);
         wbs_we_o  = wbs_we_o | (grant[k] & wbm_we_i[k]);
      end
   end

   assign wbm_dat_o = {PORTS{wbs_dat_i}};
   assign grant_o   = grant;

endmodule
